// File: rtl/hazard_unit_if.sv
// hazard_unit_if: ID-stage decode fields in, stall/flush/forward controls out.
// master = pipeline/decoder side, slave = hazard_unit.
interface hazard_unit_if;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_rD1_re;
    logic        id_rD2_re;
    logic        id_reg_we;
    logic        id_is_load;
    logic        ex_taken;
    logic        pc_stall;
    logic        if_id_stall;
    logic        id_ex_bubble;
    logic        if_id_flush;
    logic [1:0]  fwd_rs1_sel;
    logic [1:0]  fwd_rs2_sel;
    logic [15:0] hazard_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rD1_re, id_rD2_re,
               id_reg_we, id_is_load, ex_taken,
        input  pc_stall, if_id_stall, id_ex_bubble, if_id_flush,
               fwd_rs1_sel, fwd_rs2_sel, hazard_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rD1_re, id_rD2_re,
               id_reg_we, id_is_load, ex_taken,
        output pc_stall, if_id_stall, id_ex_bubble, if_id_flush,
               fwd_rs1_sel, fwd_rs2_sel, hazard_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: RAW/load-use stall, taken-branch flush and operand forwarding for a 5-stage pipe.
// Define HAZARD_FORWARD_EN to forward from EX/MEM/WB; otherwise any in-flight writer stalls ID.
module hazard_unit (
    input  logic         cpu_clk,
    input  logic         cpu_rst_n,
    hazard_unit_if.slave hz
);
    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic       load;
    } shadow_t;

    // Index 0 = EX, 1 = MEM, 2 = WB.
    shadow_t     sh_r [0:2];
    logic [15:0] cnt_r;

    logic [2:0]  m1_s;
    logic [2:0]  m2_s;
    logic        stall_s;
    logic        bubble_s;
    logic        pc_stall_s;
    logic        issue_s;
    logic [1:0]  fwd1_s;
    logic [1:0]  fwd2_s;

    function automatic logic stage_match(input shadow_t st, input logic [4:0] rs, input logic re);
        return st.we && (st.rd == rs) && (rs != 5'd0) && re;
    endfunction

`ifdef HAZARD_FORWARD_EN
    function automatic logic [1:0] fwd_pick(input logic [2:0] m);
        logic [1:0] sel;
        if (m[0]) begin
            sel = 2'b01;
        end else if (m[1]) begin
            sel = 2'b10;
        end else if (m[2]) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction
`endif

    // Match each shadow stage against the ID operands and derive stall/forward selects.
    always_comb begin
        m1_s = 3'b000;
        m2_s = 3'b000;
        for (int s = 0; s < 3; s++) begin
            m1_s[s] = hz.id_valid && stage_match(sh_r[s], hz.id_rs1, hz.id_rD1_re);
            m2_s[s] = hz.id_valid && stage_match(sh_r[s], hz.id_rs2, hz.id_rD2_re);
        end
`ifdef HAZARD_FORWARD_EN
        stall_s = sh_r[0].load && (m1_s[0] || m2_s[0]);
        fwd1_s  = fwd_pick(m1_s);
        fwd2_s  = fwd_pick(m2_s);
`else
        stall_s = (m1_s != 3'b000) || (m2_s != 3'b000);
        fwd1_s  = 2'b00;
        fwd2_s  = 2'b00;
`endif
        bubble_s   = stall_s || hz.ex_taken;
        pc_stall_s = stall_s && !hz.ex_taken;
        issue_s    = hz.id_valid && !bubble_s;
    end

    // Drive the pipeline controls; reset forces every output low without waiting for a clock.
    always_comb begin
        hz.pc_stall     = 1'b0;
        hz.if_id_stall  = 1'b0;
        hz.id_ex_bubble = 1'b0;
        hz.if_id_flush  = 1'b0;
        hz.fwd_rs1_sel  = 2'b00;
        hz.fwd_rs2_sel  = 2'b00;
        hz.hazard_cnt   = cnt_r;
        if (!cpu_rst_n) begin
            hz.hazard_cnt = 16'h0000;
        end else begin
            hz.pc_stall     = pc_stall_s;
            hz.if_id_stall  = pc_stall_s;
            hz.id_ex_bubble = bubble_s;
            hz.if_id_flush  = hz.ex_taken;
            hz.fwd_rs1_sel  = fwd1_s;
            hz.fwd_rs2_sel  = fwd2_s;
        end
    end

    // Shadow pipeline: EX takes the issued instruction or a bubble, MEM/WB always shift.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            for (int s = 0; s < 3; s++) begin
                sh_r[s] <= '{rd: 5'd0, we: 1'b0, load: 1'b0};
            end
        end else begin
            if (issue_s) begin
                sh_r[0] <= '{rd: hz.id_rd, we: hz.id_reg_we, load: hz.id_is_load};
            end else begin
                sh_r[0] <= '{rd: 5'd0, we: 1'b0, load: 1'b0};
            end
            sh_r[1] <= sh_r[0];
            sh_r[2] <= sh_r[1];
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            cnt_r <= 16'h0000;
        end else if (pc_stall_s && (cnt_r != 16'hFFFF)) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed + random stimulus, expectations from an instruction-history model,
// checked by a scoreboard monitor. Follows HAZARD_FORWARD_EN like the design.
module tb_hazard_unit;
    logic cpu_clk;
    logic cpu_rst_n;

    hazard_unit_if hif ();

    hazard_unit dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .hz        (hif)
    );

    typedef struct packed {
        bit       v;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit [4:0] rd;
        bit       re1;
        bit       re2;
        bit       we;
        bit       ld;
    } ins_t;

    typedef struct packed {
        bit [4:0] rd;
        bit       we;
        bit       ld;
    } ent_t;

    typedef struct {
        bit          ps;
        bit          fl;
        bit          bub;
        bit [1:0]    f1;
        bit [1:0]    f2;
        int unsigned cnt;
    } exp_t;

    ent_t        hist[$];   // instructions that entered EX, youngest first
    exp_t        sb[$];
    int unsigned cnt_m;
    bit          last_stall;
    int          n_cmp;
    int          n_bad;

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    function automatic ins_t alu(input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
        return '{v: 1'b1, rs1: rs1, rs2: rs2, rd: rd, re1: 1'b1, re2: 1'b1, we: 1'b1, ld: 1'b0};
    endfunction

    function automatic ins_t lw(input bit [4:0] rd, input bit [4:0] rs1);
        return '{v: 1'b1, rs1: rs1, rs2: 5'd0, rd: rd, re1: 1'b1, re2: 1'b0, we: 1'b1, ld: 1'b1};
    endfunction

    function automatic ins_t nop();
        return '{v: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, re1: 1'b0, re2: 1'b0, we: 1'b0, ld: 1'b0};
    endfunction

    // Distance (0 = EX) to the youngest in-flight writer of rs, or -1 when none.
    function automatic int find_dist(input bit [4:0] rs, input bit re);
        if (!re || rs == 5'd0) return -1;
        foreach (hist[k]) begin
            if (hist[k].we && hist[k].rd == rs) return k;
        end
        return -1;
    endfunction

    task automatic step(input ins_t i, input bit tk, input bit rst);
        exp_t e;
        int   d1;
        int   d2;
        bit   st;
        ent_t nx;
        @(posedge cpu_clk);
        #1;
        hif.id_valid   = i.v;
        hif.id_rs1     = i.rs1;
        hif.id_rs2     = i.rs2;
        hif.id_rd      = i.rd;
        hif.id_rD1_re  = i.re1;
        hif.id_rD2_re  = i.re2;
        hif.id_reg_we  = i.we;
        hif.id_is_load = i.ld;
        hif.ex_taken   = tk;
        e = '{ps: 1'b0, fl: 1'b0, bub: 1'b0, f1: 2'b00, f2: 2'b00, cnt: 0};
        if (!rst) begin
            cpu_rst_n  = 1'b0;
            hist.delete();
            cnt_m      = 0;
            last_stall = 1'b0;
            sb.push_back(e);
            return;
        end
        cpu_rst_n = 1'b1;
        d1 = i.v ? find_dist(i.rs1, i.re1) : -1;
        d2 = i.v ? find_dist(i.rs2, i.re2) : -1;
`ifdef HAZARD_FORWARD_EN
        st   = (hist.size() > 0) && hist[0].ld && (d1 == 0 || d2 == 0);
        e.f1 = (d1 < 0) ? 2'b00 : 2'(d1 + 1);
        e.f2 = (d2 < 0) ? 2'b00 : 2'(d2 + 1);
`else
        st = (d1 >= 0) || (d2 >= 0);
`endif
        e.ps  = st && !tk;
        e.fl  = tk;
        e.bub = st || tk;
        e.cnt = cnt_m;
        sb.push_back(e);
        nx = (i.v && !e.bub) ? '{rd: i.rd, we: i.we, ld: i.ld} : '{rd: 5'd0, we: 1'b0, ld: 1'b0};
        hist.push_front(nx);
        if (hist.size() > 3) void'(hist.pop_back());
        if (e.ps && cnt_m < 65535) cnt_m++;
        last_stall = e.ps;
    endtask

    // Present an instruction and keep it in ID for as long as the model says the PC is held.
    task automatic issue(input ins_t i, input bit tk);
        int guard;
        guard = 0;
        step(i, tk, 1'b1);
        while (last_stall && guard < 6) begin
            step(i, 1'b0, 1'b1);
            guard++;
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: each negedge the DUT presents one cycle of outputs; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge cpu_clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_stall",     int'(hif.pc_stall),     int'(e.ps));
                chk("if_id_stall",  int'(hif.if_id_stall),  int'(e.ps));
                chk("id_ex_bubble", int'(hif.id_ex_bubble), int'(e.bub));
                chk("if_id_flush",  int'(hif.if_id_flush),  int'(e.fl));
                chk("fwd_rs1_sel",  int'(hif.fwd_rs1_sel),  int'(e.f1));
                chk("fwd_rs2_sel",  int'(hif.fwd_rs2_sel),  int'(e.f2));
                chk("hazard_cnt",   int'(hif.hazard_cnt),   int'(e.cnt));
            end
        end
    end

    initial begin
        ins_t r;
        n_cmp      = 0;
        n_bad      = 0;
        cnt_m      = 0;
        last_stall = 1'b0;
        cpu_rst_n  = 1'b0;
        hif.id_valid = 1'b0; hif.id_rs1 = 5'd0; hif.id_rs2 = 5'd0; hif.id_rd = 5'd0;
        hif.id_rD1_re = 1'b0; hif.id_rD2_re = 1'b0; hif.id_reg_we = 1'b0;
        hif.id_is_load = 1'b0; hif.ex_taken = 1'b0;

        // Reset state, including ex_taken held high while in reset.
        step(alu(5'd3, 5'd1, 5'd2), 1'b1, 1'b0);
        step(nop(), 1'b1, 1'b0);
        step(nop(), 1'b0, 1'b0);

        // Forwarding distances 0, 1 and 2 (stalls instead without forwarding).
        issue(alu(5'd5, 5'd1, 5'd2), 1'b0);
        issue(alu(5'd6, 5'd5, 5'd1), 1'b0);
        issue(alu(5'd5, 5'd1, 5'd2), 1'b0);
        issue(nop(), 1'b0);
        issue(alu(5'd6, 5'd5, 5'd1), 1'b0);
        issue(alu(5'd5, 5'd1, 5'd2), 1'b0);
        issue(nop(), 1'b0);
        issue(nop(), 1'b0);
        issue(alu(5'd6, 5'd5, 5'd1), 1'b0);
        repeat (3) issue(nop(), 1'b0);

        // Load-use on both operands, then x0 writer/reader, then x5 RAW chain.
        issue(lw(5'd7, 5'd1), 1'b0);
        issue(alu(5'd8, 5'd7, 5'd7), 1'b0);
        issue(alu(5'd0, 5'd1, 5'd2), 1'b0);
        issue(alu(5'd9, 5'd0, 5'd0), 1'b0);
        repeat (3) issue(nop(), 1'b0);
        issue(alu(5'd5, 5'd1, 5'd2), 1'b0);
        issue(alu(5'd6, 5'd5, 5'd0), 1'b0);

        // Load-use coinciding with a taken branch in EX.
        issue(lw(5'd7, 5'd1), 1'b0);
        issue(alu(5'd8, 5'd7, 5'd7), 1'b1);

        // Reset dropped in the middle of a stall, then restart as from cold.
        issue(lw(5'd7, 5'd1), 1'b0);
        step(alu(5'd8, 5'd7, 5'd7), 1'b0, 1'b1);
        step(alu(5'd8, 5'd7, 5'd7), 1'b0, 1'b0);
        step(nop(), 1'b0, 1'b0);
        issue(lw(5'd7, 5'd1), 1'b0);
        issue(alu(5'd8, 5'd7, 5'd7), 1'b0);

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            r.v   = ($urandom_range(0, 9) != 0);
            r.rs1 = 5'($urandom_range(0, 7));
            r.rs2 = 5'($urandom_range(0, 7));
            r.rd  = 5'($urandom_range(0, 7));
            r.re1 = ($urandom_range(0, 4) != 0);
            r.re2 = ($urandom_range(0, 2) != 0);
            r.we  = ($urandom_range(0, 4) != 0);
            r.ld  = r.we && ($urandom_range(0, 2) == 0);
            if (n == 200) begin
                step(r, 1'b0, 1'b0);
            end else begin
                issue(r, ($urandom_range(0, 7) == 0));
            end
        end

        repeat (3) @(negedge cpu_clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 cpu_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 cpu_rst_n  in  1  reset, asynchronous, active-low.
REQ-003 id_valid  in  1  ID stage holds a real instruction.
REQ-004 id_rs1, id_rs2, id_rd  in  5 each  register fields of the ID instruction.
REQ-005 id_rD1_re, id_rD2_re  in  1 each  ID instruction reads rs1/rs2; these are the decoder's read enables.
REQ-006 id_reg_we  in  1  ID instruction writes rd.
REQ-007 id_is_load  in  1  ID instruction is a load (decoder reg_write == 2'b10).
REQ-008 ex_taken  in  1  instruction now in EX redirects the PC (taken branch, jal, jalr).
REQ-009 pc_stall, if_id_stall  out  1 each  hold PC and IF/ID register.
REQ-010 id_ex_bubble  out  1  load NOP into ID/EX.
REQ-011 if_id_flush  out  1  load NOP into IF/ID.
REQ-012 fwd_rs1_sel, fwd_rs2_sel  out  2 each  ID operand source: 00 regfile, 01 EX result, 10 MEM result, 11 WB data.
REQ-013 hazard_cnt  out  16  saturating count of stall cycles.

Function
REQ-014 The unit SHALL keep shadow state {rd, we, load} for EX, MEM and WB; each cycle MEM<=EX and WB<=MEM.
REQ-015 EX shadow SHALL load the ID fields when the stage advances, and a bubble (we=0, load=0) when id_ex_bubble=1 or id_valid=0.
REQ-016 A stage "matches" rsN when its we=1, its rd==rsN, rsN!=0 and the matching read enable is 1.
REQ-017 Forwarding SHALL give EX priority over MEM, and MEM priority over WB; with no match the select SHALL be 00.
REQ-018 Load-use hazard: EX load=1 and EX matches rs1 or rs2 -> stall=1 for that cycle.
REQ-019 When stall=1: pc_stall=if_id_stall=id_ex_bubble=1, if_id_flush=0.
REQ-020 Because of the bubble, a load-use stall SHALL last exactly 1 cycle; the load is then in MEM and fwd_sel=10.
REQ-021 ex_taken=1 -> if_id_flush=1, id_ex_bubble=1, pc_stall=if_id_stall=0 in the same cycle. Combinational, 0-cycle latency.
REQ-022 Simultaneous ex_taken and stall: the flush SHALL win and all stall outputs SHALL be 0.
REQ-023 id_valid=0 SHALL suppress every hazard: no stall, fwd_sel=00.
REQ-024 All hazard and forward outputs SHALL be combinational from shadow state plus the current inputs.
REQ-025 hazard_cnt SHALL increment on every edge with pc_stall=1, and SHALL hold at 16'hFFFF.

Reset
REQ-026 cpu_rst_n=0 SHALL clear every shadow rd/we/load and hazard_cnt to 0 immediately, with no clock edge required.
REQ-027 During reset all outputs SHALL be 0.
REQ-028 A reset asserted mid-stall SHALL drop the stall at once.
REQ-029 After release, the first ID instruction SHALL see no hazard.

Configuration
REQ-030 Macro HAZARD_FORWARD_EN defined: forwarding per REQ-017, and a stall only on the load-use hazard of REQ-018.
REQ-031 HAZARD_FORWARD_EN undefined: fwd_rs1_sel and fwd_rs2_sel SHALL be tied to 00.
REQ-032 HAZARD_FORWARD_EN undefined: stall=1 whenever EX, MEM or WB matches rs1 or rs2 (regfile write-before-read is not assumed), and the shadow pipeline SHALL keep advancing during the stall.

Verification
REQ-033 FORWARD_EN: add x5 then add x6,x5,x1 -> fwd_rs1_sel=01, no stall; one cycle later with a gap -> 10; two gaps -> 11.
REQ-034 FORWARD_EN: lw x7 then add x8,x7,x7 -> exactly 1 stall cycle with id_ex_bubble=1, then fwd_rs1_sel=fwd_rs2_sel=10; hazard_cnt becomes 1.
REQ-035 Writer with rd=x0 followed by a reader of x0 -> fwd_sel=00, no stall, in both configurations.
REQ-036 lw x7 in EX with load-use, plus ex_taken=1 in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_stall=0.
REQ-037 No FORWARD_EN: add x5 then add x6,x5,x0 -> 3 stall cycles while x5 moves EX->MEM->WB, then release; hazard_cnt=3.
REQ-038 cpu_rst_n pulled low mid-stall (no clock edge) -> all outputs 0 immediately, hazard_cnt=0; sequence restarted after release behaves as from cold reset.
